cdf_accumulate: RTL and testbench

Running-sum stage of the CDF pipeline, directly downstream of the histogram fetch stage. It consumes the fetch stage's per-bin count stream (one 20-bit count per cycle with a paired store address) and forms the cumulative distribution. Each cumulative value is written back to memory as a tagged word at the paired address, and the block reports the minimum non-zero CDF value and the total for the equalization stage that follows.

---
 rtl/cdf_accumulate.sv | 173 +++++++++++++++++
 tb/tb_cdf_accumulate.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdf_accumulate.sv
// cdf_accumulate
// Running-sum stage of the CDF pipeline. It accumulates one histogram bin
// count per accepted sample and saturates the sum at all-ones. Each
// cumulative value is written back through a registered, tagged write port.
// The block also reports the first non-zero CDF value and the pass total.
module cdf_accumulate #(
    parameter int          DATA_W = 20,
    parameter int          ADDR_W = 16,
    parameter int          BINS   = 256,
    parameter logic [15:0] TAG    = 16'hAAAA
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] AccumlateIn,
    input  logic              StartIn,
    input  logic [ADDR_W-1:0] StoreAddrIn,
    output logic [127:0]      WriteBus,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic              WriteEn,
    output logic [DATA_W-1:0] CdfMin,
    output logic [DATA_W-1:0] CdfTotal,
    output logic              Overflow,
    output logic              done
);

    localparam int                CNT_W  = $clog2(BINS + 1);
    localparam logic [CNT_W-1:0]  BINS_C = CNT_W'(BINS);
    localparam int                PAD_W  = 128 - 16 - DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Unsigned add with a sticky saturation input. The MSB of the result
    // flags saturation, and the lower DATA_W bits carry the clipped sum.
    function automatic logic [DATA_W:0] sat_add(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] x,
        input logic              sticky
    );
        logic [DATA_W:0] s;
        s = {1'b0, acc} + {1'b0, x};
        if (s[DATA_W] || sticky) begin
            sat_add = {1'b1, {DATA_W{1'b1}}};
        end else begin
            sat_add = {1'b0, s[DATA_W-1:0]};
        end
    endfunction

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_sum_p0;
    logic [CNT_W-1:0]  r_count_p0;
    logic              r_ovf_p0;
    logic              r_min_seen_p0;

    logic              r_vld_p1;
    logic [DATA_W-1:0] r_wr_data_p1;
    logic [ADDR_W-1:0] r_wr_addr_p1;
    logic              r_min_load_p1;

    logic [DATA_W-1:0] r_cdf_min_p2;
    logic [DATA_W-1:0] r_total;
    logic              r_done;

    logic              w_accept;
    logic              w_sat_p0;
    logic [DATA_W-1:0] w_sum_next_p0;
    logic              w_min_hit;

    // A sample is taken on the IDLE->ACCUM transition cycle too. Once the
    // last bin has been counted, ACCUM must refuse samples for the single
    // cycle it spends before moving to DONE.
    assign w_accept = start && StartIn &&
                      ((r_state == S_IDLE) ||
                       ((r_state == S_ACCUM) && (r_count_p0 != BINS_C)));

    assign {w_sat_p0, w_sum_next_p0} = sat_add(r_sum_p0, AccumlateIn, r_ovf_p0);

    assign w_min_hit = w_accept && !r_min_seen_p0 && (w_sum_next_p0 != '0);

    // Pass sequencing: IDLE -> ACCUM -> DONE. Dropping start returns to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (!start) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_ACCUM;
                S_ACCUM: if (r_count_p0 == BINS_C) r_state <= S_DONE;
                S_DONE:  r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage 0: the saturating accumulator and the accepted-sample counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sum_p0      <= '0;
            r_count_p0    <= '0;
            r_ovf_p0      <= 1'b0;
            r_min_seen_p0 <= 1'b0;
        end else if (!start) begin
            r_sum_p0      <= '0;
            r_count_p0    <= '0;
            r_ovf_p0      <= 1'b0;
            r_min_seen_p0 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum_p0   <= w_sum_next_p0;
                r_count_p0 <= r_count_p0 + 1'b1;
                if (w_sat_p0) r_ovf_p0 <= 1'b1;
            end
            if (w_min_hit) r_min_seen_p0 <= 1'b1;
        end
    end

    // Stage 1: a registered write port that carries one strobe per accepted sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p1      <= 1'b0;
            r_wr_data_p1  <= '0;
            r_wr_addr_p1  <= '0;
            r_min_load_p1 <= 1'b0;
        end else if (!start) begin
            r_vld_p1      <= 1'b0;
            r_wr_data_p1  <= '0;
            r_wr_addr_p1  <= '0;
            r_min_load_p1 <= 1'b0;
        end else begin
            r_vld_p1      <= w_accept;
            r_wr_data_p1  <= w_accept ? w_sum_next_p0 : '0;
            r_wr_addr_p1  <= w_accept ? StoreAddrIn : '0;
            r_min_load_p1 <= w_min_hit;
        end
    end

    // Stage 2: capture CdfMin from the write that first carried a non-zero value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cdf_min_p2 <= '0;
        end else if (!start) begin
            r_cdf_min_p2 <= '0;
        end else if (r_min_load_p1) begin
            r_cdf_min_p2 <= r_wr_data_p1;
        end
    end

    // Pass completion: latch the total and raise done when ACCUM hands over to DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_total <= '0;
            r_done  <= 1'b0;
        end else if (!start) begin
            r_total <= '0;
            r_done  <= 1'b0;
        end else if ((r_state == S_ACCUM) && (r_count_p0 == BINS_C)) begin
            r_total <= r_sum_p0;
            r_done  <= 1'b1;
        end
    end

    assign WriteEn   = r_vld_p1;
    assign WriteBus  = r_vld_p1 ? {{PAD_W{1'b0}}, TAG, r_wr_data_p1} : 128'b0;
    assign WriteAddr = r_vld_p1 ? r_wr_addr_p1 : '0;
    assign CdfMin    = r_cdf_min_p2;
    assign CdfTotal  = r_total;
    assign Overflow  = r_ovf_p0;
    assign done      = r_done;

endmodule

// File: tb/tb_cdf_accumulate.sv
// Testbench for cdf_accumulate. A pass-level model computes the expected
// outputs. Each write is min(prefix sum, 2^20-1) over the first 256
// accepted samples.
module tb_cdf_accumulate;

    localparam int          BINS = 256;
    localparam logic [15:0] TAG  = 16'hAAAA;
    localparam longint      SATV = 64'hFFFFF;

    logic         clock;
    logic         reset;
    logic         start;
    logic [19:0]  AccumlateIn;
    logic         StartIn;
    logic [15:0]  StoreAddrIn;
    logic [127:0] WriteBus;
    logic [15:0]  WriteAddr;
    logic         WriteEn;
    logic [19:0]  CdfMin;
    logic [19:0]  CdfTotal;
    logic         Overflow;
    logic         done;

    int checks = 0;
    int errors = 0;

    // pass model state
    longint      m_sum;
    int          m_acc;
    logic        m_found;
    logic [19:0] m_min;

    cdf_accumulate dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .AccumlateIn (AccumlateIn),
        .StartIn     (StartIn),
        .StoreAddrIn (StoreAddrIn),
        .WriteBus    (WriteBus),
        .WriteAddr   (WriteAddr),
        .WriteEn     (WriteEn),
        .CdfMin      (CdfMin),
        .CdfTotal    (CdfTotal),
        .Overflow    (Overflow),
        .done        (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [19:0] clip(input longint s);
        return (s > SATV) ? 20'hFFFFF : s[19:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_sum   = 0;
        m_acc   = 0;
        m_found = 1'b0;
        m_min   = 20'h0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_we"},    128'(WriteEn),   128'h0);
        chk({tag, "_bus"},   WriteBus,        128'h0);
        chk({tag, "_addr"},  128'(WriteAddr), 128'h0);
        chk({tag, "_min"},   128'(CdfMin),    128'h0);
        chk({tag, "_total"}, 128'(CdfTotal),  128'h0);
        chk({tag, "_ovf"},   128'(Overflow),  128'h0);
        chk({tag, "_done"},  128'(done),      128'h0);
    endtask

    // One clock: drive a sample with the current start level, then check every output after the edge.
    task automatic step(input logic sv, input logic [19:0] d, input logic [15:0] a);
        logic        exp_we;
        logic        full_prev;
        logic        found_prev;
        logic [19:0] min_prev;
        logic [19:0] exp_data;
        logic        exp_done;
        if (!start) model_clear();
        full_prev  = (m_acc == BINS);
        found_prev = m_found;
        min_prev   = m_min;
        exp_we     = start && sv && (m_acc < BINS);
        exp_data   = 20'h0;
        if (exp_we) begin
            m_sum    = m_sum + longint'(d);
            m_acc    = m_acc + 1;
            exp_data = clip(m_sum);
            if (!m_found && exp_data != 20'h0) begin
                m_found = 1'b1;
                m_min   = exp_data;
            end
        end
        exp_done    = start && full_prev;
        StartIn     = sv;
        AccumlateIn = d;
        StoreAddrIn = a;
        @(posedge clock);
        #1;
        chk("we",    128'(WriteEn), 128'(exp_we));
        chk("bus",   WriteBus, exp_we ? {92'b0, TAG, exp_data} : 128'h0);
        chk("addr",  128'(WriteAddr), exp_we ? 128'(a) : 128'h0);
        chk("done",  128'(done), 128'(exp_done));
        chk("total", 128'(CdfTotal), exp_done ? 128'(clip(m_sum)) : 128'h0);
        chk("ovf",   128'(Overflow), 128'(start && (m_sum > SATV)));
        chk("min",   128'(CdfMin), (start && found_prev) ? 128'(min_prev) : 128'h0);
    endtask

    // Asynchronous reset pulse that lands between clock edges.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 check_zero("rst_async");
        #1 reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [19:0] d;
        reset       = 1'b1;
        start       = 1'b0;
        StartIn     = 1'b0;
        AccumlateIn = 20'h0;
        StoreAddrIn = 16'h0;
        model_clear();
        #12;
        check_zero("reset");
        reset = 1'b0;
        step(1'b1, 20'h5, 16'h1);  // start low: must not write

        // uniform pass
        start = 1'b1;
        for (int i = 0; i < BINS; i++) step(1'b1, 20'd1, 16'(16'h8000 + i));
        step(1'b0, 20'h0, 16'h0);
        step(1'b0, 20'h0, 16'h0);
        chk("uni_total", 128'(CdfTotal), 128'd256);
        chk("uni_min",   128'(CdfMin),   128'd1);
        start = 1'b0;
        step(1'b0, 20'h0, 16'h0);

        // leading zeros
        start = 1'b1;
        for (int i = 0; i < BINS; i++) begin
            d = (i < 10) ? 20'd0 : ((i == 10) ? 20'd5 : 20'd1);
            step(1'b1, d, 16'(i));
        end
        step(1'b0, 20'h0, 16'h0);
        chk("lz_total", 128'(CdfTotal), 128'd250);
        chk("lz_min",   128'(CdfMin),   128'd5);
        start = 1'b0;
        step(1'b0, 20'h0, 16'h0);

        // saturation
        start = 1'b1;
        for (int i = 0; i < BINS; i++) begin
            if (i == 0)      d = 20'hFFFF0;
            else if (i == 1) d = 20'h20;
            else             d = 20'($urandom_range(0, 100));
            step(1'b1, d, 16'($urandom));
        end
        step(1'b0, 20'h0, 16'h0);
        chk("sat_ovf",   128'(Overflow), 128'd1);
        chk("sat_total", 128'(CdfTotal), 128'hFFFFF);
        start = 1'b0;
        step(1'b0, 20'h0, 16'h0);

        // bubbles
        start = 1'b1;
        for (int c = 0; c < 512; c++)
            step(((c % 2) == 0), 20'($urandom_range(0, 4095)), 16'($urandom));
        step(1'b1, 20'h7, 16'h7);
        step(1'b1, 20'h7, 16'h7);
        start = 1'b0;
        step(1'b0, 20'h0, 16'h0);

        // extra samples beyond BINS
        start = 1'b1;
        for (int i = 0; i < 300; i++) step(1'b1, 20'($urandom_range(0, 2000)), 16'(i));
        step(1'b0, 20'h0, 16'h0);
        step(1'b1, 20'h3, 16'h3);
        chk("extra_done", 128'(done), 128'd1);
        start = 1'b0;
        step(1'b1, 20'h3, 16'h3);
        check_zero("extra_clear");

        // abort by reset
        start = 1'b1;
        for (int i = 0; i < 100; i++) step(1'b1, 20'($urandom_range(0, 3000)), 16'(i));
        pulse_reset();
        for (int i = 0; i < BINS; i++) step(1'b1, 20'($urandom_range(0, 3000)), 16'(i + 16'h100));
        step(1'b0, 20'h0, 16'h0);
        start = 1'b0;
        step(1'b0, 20'h0, 16'h0);

        // abort by dropping start
        start = 1'b1;
        for (int i = 0; i < 100; i++) step(1'b1, 20'($urandom_range(0, 3000)), 16'(i));
        start = 1'b0;
        step(1'b1, 20'h9, 16'h9);
        check_zero("abort_clear");
        start = 1'b1;
        for (int i = 0; i < BINS; i++) step(1'b1, 20'($urandom_range(1, 3000)), 16'(i + 16'h200));
        step(1'b0, 20'h0, 16'h0);
        step(1'b0, 20'h0, 16'h0);
        start = 1'b0;
        step(1'b0, 20'h0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
